// File: rtl/dtw_result_packer.sv
// rtl/dtw_result_packer.sv - pops DTW result records from the sink FIFO and emits them as 3-beat AXI-Stream packets
module dtw_result_packer #(
    parameter int dtw_dwidth = 16,
    parameter int axi_dwidth = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       fifo_empty,
    output logic                       fifo_rden,
    input  logic [64+dtw_dwidth-1:0]   fifo_data,
    output logic [axi_dwidth-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic [31:0]                result_count
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        BEAT_QID,
        BEAT_POS,
        BEAT_MIN
    } state_t;

    state_t                state;
    logic [31:0]           qid_r;
    logic [31:0]           pos_r;
    logic [dtw_dwidth-1:0] min_r;

    // The pop strobe must be combinational so the FIFO presents data in LATCH.
    assign fifo_rden = !rst && (state == IDLE) && enable && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            qid_r         <= '0;
            pos_r         <= '0;
            min_r         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            result_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_rden) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    qid_r         <= fifo_data[64+dtw_dwidth-1 -: 32];
                    pos_r         <= fifo_data[32+dtw_dwidth-1 -: 32];
                    min_r         <= fifo_data[dtw_dwidth-1:0];
                    m_axis_tdata  <= fifo_data[64+dtw_dwidth-1 -: 32];
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= 1'b0;
                    state         <= BEAT_QID;
                end
                BEAT_QID: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= pos_r;
                        state        <= BEAT_POS;
                    end else begin
                        m_axis_tdata <= qid_r;
                    end
                end
                BEAT_POS: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= axi_dwidth'(min_r);
                        m_axis_tlast <= 1'b1;
                        state        <= BEAT_MIN;
                    end
                end
                BEAT_MIN: begin
                    if (m_axis_tready) begin
                        m_axis_tdata  <= '0;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        busy          <= 1'b0;
                        result_count  <= result_count + 32'd1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_result_packer.sv
// tb/tb_dtw_result_packer.sv - directed self-checking bench for dtw_result_packer
module tb_dtw_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty = 1'b1;
    logic        fifo_rden;
    logic [79:0] fifo_data = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [31:0] result_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [79:0] fifo_q[$];
    int          rden_cyc[$];
    logic [31:0] beat_data[$];
    logic        beat_last[$];
    int          beat_cyc[$];

    dtw_result_packer #(.dtw_dwidth(16), .axi_dwidth(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_rden     (fifo_rden),
        .fifo_data     (fifo_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .result_count  (result_count)
    );

    always #5 clk = ~clk;

    // FIFO model (data valid the cycle after the strobe) plus stream/pop monitor.
    always @(posedge clk) begin
        if (fifo_rden) begin
            rden_cyc.push_back(cyc);
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
        if (m_axis_tvalid && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_last.push_back(m_axis_tlast);
            beat_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] qid, input logic [31:0] pos, input logic [15:0] minv);
        fifo_q.push_back({qid, pos, minv});
    endtask

    task automatic clear_logs();
        rden_cyc.delete();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && beat_data.size() < n; i++) tick();
        check(tag, beat_data.size(), n);
    endtask

    task automatic check_packet(input string tag, input int base,
                                input logic [31:0] qid, input logic [31:0] pos, input logic [31:0] minv);
        check({tag, "_qid"}, beat_data[base], qid);
        check({tag, "_pos"}, beat_data[base+1], pos);
        check({tag, "_min"}, beat_data[base+2], minv);
        check({tag, "_last"}, {29'd0, beat_last[base], beat_last[base+1], beat_last[base+2]}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_count", result_count, 0);
        check("rst_rden", fifo_rden, 0);
        rst = 1'b0;
        tick();

        // Single record, tready high: beats at pop+2..pop+4.
        clear_logs();
        m_axis_tready = 1'b1;
        enable        = 1'b1;
        push(32'h7, 32'h1234, 16'h00FF);
        wait_beats(3, 30, "single_beats");
        tick();
        check("single_pops", rden_cyc.size(), 1);
        check("single_lat0", beat_cyc[0] - rden_cyc[0], 2);
        check("single_lat1", beat_cyc[1] - rden_cyc[0], 3);
        check("single_lat2", beat_cyc[2] - rden_cyc[0], 4);
        check_packet("single", 0, 32'h7, 32'h1234, 32'h000000FF);
        check("single_count", result_count, 1);
        check("single_busy", busy, 0);

        // Backpressure: three stalled cycles per beat, outputs frozen.
        clear_logs();
        m_axis_tready = 1'b0;
        push(32'h7, 32'h1234, 16'h00FF);
        for (int i = 0; i < 30 && !m_axis_tvalid; i++) tick();
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 3; s++) begin
                check("bp_stall", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                      (b == 0) ? {2'b10, 32'h7} : (b == 1) ? {2'b10, 32'h1234} : {2'b11, 32'hFF});
                tick();
            end
            m_axis_tready = 1'b1;
            tick();
            m_axis_tready = 1'b0;
        end
        repeat (2) tick();
        check("bp_handshakes", beat_data.size(), 3);
        check_packet("bp", 0, 32'h7, 32'h1234, 32'h000000FF);
        check("bp_count", result_count, 2);
        check("bp_tvalid_after", m_axis_tvalid, 0);

        // Stream of four records, one pop every 5 cycles, FIFO order.
        clear_logs();
        m_axis_tready = 1'b1;
        for (int r = 0; r < 4; r++) push(32'h10 + r, 32'h100 + r, 16'hA000 + 16'(r));
        wait_beats(12, 80, "stream_beats");
        repeat (8) tick();
        check("stream_pops", rden_cyc.size(), 4);
        for (int r = 1; r < 4; r++) check("stream_period", rden_cyc[r] - rden_cyc[r-1], 5);
        for (int r = 0; r < 4; r++)
            check_packet("stream", 3*r, 32'h10 + r, 32'h100 + r, 32'hA000 + r);
        check("stream_count", result_count, 6);

        // Enable gating: no pop while low, packet completes after a mid-packet drop.
        clear_logs();
        enable = 1'b0;
        push(32'h21, 32'h2222, 16'h0321);
        repeat (10) tick();
        check("gate_no_pop", rden_cyc.size(), 0);
        check("gate_busy", busy, 0);
        enable = 1'b1;
        wait_beats(1, 20, "gate_first_beat");
        enable = 1'b0;
        push(32'h31, 32'h3131, 16'h0031);
        wait_beats(3, 20, "gate_beats");
        repeat (10) tick();
        check("gate_pops", rden_cyc.size(), 1);
        check_packet("gate", 0, 32'h21, 32'h2222, 32'h321);
        check("gate_count", result_count, 7);

        // Reset asserted during BEAT_POS drops the packet at once.
        clear_logs();
        enable = 1'b1;
        wait_beats(1, 20, "rst_first_beat");
        rst = 1'b1;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tlast", m_axis_tlast, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", result_count, 0);
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        push(32'h41, 32'h4141, 16'h0041);
        wait_beats(3, 30, "postrst_beats");
        tick();
        check_packet("postrst", 0, 32'h41, 32'h4141, 32'h41);
        check("postrst_count", result_count, 1);

        // Counter wrap.
        clear_logs();
        force dut.result_count = 32'hFFFF_FFFF;
        tick();
        release dut.result_count;
        tick();
        check("wrap_preload", result_count, 32'hFFFF_FFFF);
        push(32'h51, 32'h5151, 16'hFFFF);
        wait_beats(3, 30, "wrap_beats");
        tick();
        check_packet("wrap", 0, 32'h51, 32'h5151, 32'h0000FFFF);
        check("wrap_count", result_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
